// File: rtl/random_modulo_ctrl_pkg.sv
// Shared definitions for the random-modulo Benes control generator:
// FSM state encoding, Galois LFSR feedback mask and power-on seed.
package random_modulo_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GEN   = 2'd1,
        FLUSH = 2'd2
    } rm_ctrl_state_t;

    localparam logic [15:0] RM_LFSR_MASK = 16'hB400;
    localparam logic [15:0] RM_LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/random_modulo_ctrl_lfsr.sv
// Right-shifting Galois LFSR (module rm_lfsr). Steps only when enabled; an explicit
// load takes priority over stepping and reset returns it to the fixed seed.
module rm_lfsr
    import random_modulo_ctrl_pkg::*;
#(
    parameter int LFSR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] state
);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LFSR_W'(RM_LFSR_SEED);
        end else if (load) begin
            state <= load_val;
        end else if (en) begin
            state <= state[0] ? ((state >> 1) ^ LFSR_W'(RM_LFSR_MASK)) : (state >> 1);
        end
    end

endmodule

// File: rtl/random_modulo_ctrl.sv
// Generates a fresh Benes permutation word from an LFSR, flushes the L1 cache and
// then commits the word atomically. Optional auto-reseed: RM_CTRL_PERIODIC_RESEED_EN.
module random_modulo_ctrl
    import random_modulo_ctrl_pkg::*;
#(
    parameter int CNT           = 12,
    parameter int LFSR_W        = 16,
    parameter int RESEED_PERIOD = 65536
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reseed_req,
    output logic              reseed_ack,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_i,
    output logic              flush_req,
    input  logic              flush_done,
    output logic [CNT-1:0]    control_o,
    output logic              busy
);

    localparam int CNT_W = $clog2(CNT + 1);

    rm_ctrl_state_t    state, next_state;
    logic [LFSR_W-1:0] lfsr_state;
    logic [CNT-1:0]    shadow;
    logic [CNT_W-1:0]  bit_cnt;
    logic              req_any, start, last_bit, commit;
    logic              lfsr_en, lfsr_load;
    logic              ack_d, flush_req_d, busy_d;
    logic              unused_lfsr_hi;

    assign unused_lfsr_hi = ^lfsr_state[LFSR_W-1:1];

`ifdef RM_CTRL_PERIODIC_RESEED_EN
    localparam int PER_W = (RESEED_PERIOD > 2) ? $clog2(RESEED_PERIOD) : 1;
    logic [PER_W-1:0] period_cnt;
    logic             auto_req;

    assign auto_req = (period_cnt == PER_W'(RESEED_PERIOD - 1));
    assign req_any  = reseed_req | auto_req;

    // Saturates at the trigger value so a request blocked by the ack cycle retries.
    always_ff @(posedge clk) begin
        if (reset || start) begin
            period_cnt <= '0;
        end else if (state == IDLE && !auto_req) begin
            period_cnt <= period_cnt + 1'b1;
        end
    end
`else
    logic unused_period;
    assign unused_period = (RESEED_PERIOD == 0);
    assign req_any       = reseed_req;
`endif

    assign start    = (state == IDLE) && req_any && !reseed_ack;
    assign last_bit = (bit_cnt == CNT_W'(CNT - 1));
    assign commit   = (state == FLUSH) && flush_done;

    rm_lfsr #(.LFSR_W(LFSR_W)) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .en       (lfsr_en),
        .load     (lfsr_load),
        .load_val (seed_i),
        .state    (lfsr_state)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start)      next_state = GEN;
            GEN:     if (last_bit)   next_state = FLUSH;
            FLUSH:   if (flush_done) next_state = IDLE;
            default:                 next_state = IDLE;
        endcase
    end

    // A zero seed would lock the LFSR, so it is dropped along with non-IDLE loads.
    always_comb begin
        lfsr_en     = (state == GEN);
        lfsr_load   = (state == IDLE) && seed_load && (seed_i != '0);
        ack_d       = commit;
        flush_req_d = (next_state == FLUSH);
        busy_d      = (next_state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow     <= '0;
            control_o  <= '0;
            bit_cnt    <= '0;
            reseed_ack <= 1'b0;
            flush_req  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            reseed_ack <= ack_d;
            flush_req  <= flush_req_d;
            busy       <= busy_d;
            if (start) begin
                bit_cnt <= '0;
            end else if (state == GEN) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (state == GEN) begin
                shadow <= (shadow << 1) | CNT'(lfsr_state[0]);
            end
            // control_o only moves here, after the cache has been flushed.
            if (commit) begin
                control_o <= shadow;
            end
        end
    end

endmodule

// File: tb/tb_random_modulo_ctrl.sv
// Directed bench for random_modulo_ctrl: table of seed/reseed vectors with
// hand-computed Benes words plus sequences for flush stall, reset abort and ack gap.
module tb_random_modulo_ctrl;

    localparam int CNT    = 12;
    localparam int LFSR_W = 16;

    logic              clk = 1'b0;
    logic              reset, reseed_req, reseed_ack, seed_load, flush_req, flush_done, busy;
    logic [LFSR_W-1:0] seed_i;
    logic [CNT-1:0]    control_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    random_modulo_ctrl #(.CNT(CNT), .LFSR_W(LFSR_W), .RESEED_PERIOD(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .reseed_req (reseed_req),
        .reseed_ack (reseed_ack),
        .seed_load  (seed_load),
        .seed_i     (seed_i),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .control_o  (control_o),
        .busy       (busy)
    );

    typedef struct {
        logic           rst;
        logic           ld;
        logic [15:0]    seed;
        logic           together;
        logic [CNT-1:0] exp_word;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        for (int c = 1; c <= 60 && n == 0; c++) begin
            tick();
            if (reseed_ack) n = c;
        end
    endtask

    task automatic wait_flush(output int n);
        n = 0;
        for (int c = 1; c <= 60 && n == 0; c++) begin
            tick();
            if (flush_req) n = c;
        end
    endtask

    // Cycle 1 is the first cycle after the request is sampled.
    task automatic run_reseed(input logic ld, input logic [15:0] sd, input logic together,
                              output int ack_cyc, output int busy_cnt);
        if (ld && !together) begin
            seed_load = 1'b1;
            seed_i    = sd;
            tick();
            seed_load = 1'b0;
        end
        if (ld && together) begin
            seed_load = 1'b1;
            seed_i    = sd;
        end
        reseed_req = 1'b1;
        tick();
        reseed_req = 1'b0;
        seed_load  = 1'b0;
        ack_cyc    = 0;
        busy_cnt   = 0;
        for (int c = 1; c <= 40 && ack_cyc == 0; c++) begin
            if (reseed_ack) begin
                ack_cyc = c;
            end else begin
                if (busy) busy_cnt++;
                tick();
            end
        end
    endtask

    initial begin
        int ack_cyc, busy_cnt, n;

        vecs[0] = '{rst: 1'b1, ld: 1'b1, seed: 16'h0001, together: 1'b1, exp_word: 12'h801};
        vecs[1] = '{rst: 1'b0, ld: 1'b0, seed: 16'h0000, together: 1'b0, exp_word: 12'h682};
        vecs[2] = '{rst: 1'b1, ld: 1'b1, seed: 16'hFFFF, together: 1'b0, exp_word: 12'hFFE};
        vecs[3] = '{rst: 1'b1, ld: 1'b1, seed: 16'h0000, together: 1'b1, exp_word: 12'h872};

        reset      = 1'b0;
        reseed_req = 1'b0;
        seed_load  = 1'b0;
        seed_i     = '0;
        flush_done = 1'b1;

        do_reset();
        check("reset_control", control_o, 0);
        check("reset_busy", busy, 0);
        check("reset_flush_req", flush_req, 0);
        check("reset_ack", reseed_ack, 0);

`ifdef RM_CTRL_PERIODIC_RESEED_EN
        n = 0;
        for (int c = 1; c <= 40 && n == 0; c++) begin
            tick();
            if (busy) n = c;
        end
        check("auto_gen_entry", n, 16);
        wait_ack(n);
        check("auto_ack_seen", (n != 0), 1);
        do_reset();
`endif

        // Zero seed ignored, then basic reseed from 16'hACE1.
        run_reseed(1'b1, 16'h0000, 1'b0, ack_cyc, busy_cnt);
        check("a_ack_cycle", ack_cyc, 14);
        check("a_busy_cycles", busy_cnt, 13);
        check("a_word", control_o, 12'h872);
        tick();
        check("a_ack_one_cycle", reseed_ack, 0);
        check("a_idle_after", busy, 0);

        // Flush stall: LFSR continues from 16'h562C.
        flush_done = 1'b0;
        reseed_req = 1'b1;
        tick();
        reseed_req = 1'b0;
        wait_flush(n);
        check("c_flush_seen", (n != 0), 1);
        for (int c = 0; c < 20; c++) begin
            check("c_flush_held", flush_req, 1);
            check("c_word_stable", control_o, 12'h872);
            check("c_no_ack", reseed_ack, 0);
            tick();
        end
        flush_done = 1'b1;
        tick();
        check("c_ack_after_done", reseed_ack, 1);
        check("c_word", control_o, 12'h346);
        check("c_flush_dropped", flush_req, 0);

        // Reset in FLUSH abandons the reseed.
        tick();
        flush_done = 1'b0;
        reseed_req = 1'b1;
        tick();
        reseed_req = 1'b0;
        wait_flush(n);
        check("d_flush_seen", (n != 0), 1);
        check("d_word_before", control_o, 12'h346);
        do_reset();
        check("d_flush_req", flush_req, 0);
        check("d_busy", busy, 0);
        check("d_control", control_o, 0);
        check("d_ack", reseed_ack, 0);
        flush_done = 1'b1;
        tick();
        check("d_ack_later", reseed_ack, 0);

        for (int i = 0; i < 4; i++) begin
            if (vecs[i].rst) do_reset();
            run_reseed(vecs[i].ld, vecs[i].seed, vecs[i].together, ack_cyc, busy_cnt);
            check($sformatf("vec%0d_ack_cycle", i), ack_cyc, 14);
            check($sformatf("vec%0d_word", i), control_o, vecs[i].exp_word);
            tick();
        end

        // Seed load during GEN must be ignored.
        do_reset();
        reseed_req = 1'b1;
        tick();
        reseed_req = 1'b0;
        tick();
        tick();
        seed_load = 1'b1;
        seed_i    = 16'h0001;
        tick();
        tick();
        tick();
        seed_load = 1'b0;
        wait_ack(n);
        check("b_ack_seen", (n != 0), 1);
        check("b_word", control_o, 12'h872);

        // A request still high in the ack cycle is not accepted.
        do_reset();
        reseed_req = 1'b1;
        tick();
        wait_ack(n);
        check("e_first_ack", (n != 0), 1);
        tick();
        check("e_ack_cycle_ignored", busy, 0);
        tick();
        check("e_next_accepted", busy, 1);
        reseed_req = 1'b0;
        wait_ack(n);
        check("e_second_ack", (n != 0), 1);
        check("e_second_word", control_o, 12'h346);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
